lsf_event_sequencer: RTL and testbench
======================================

# lsf_event_sequencer

Sequences one event at a time from the ROI and MDT-hit input FIFOs into the Legendre segment-finder engine. It pops one ROI, then streams that ROI's hits up to the histogram accumulation limit and discards any excess. It then signals end-of-accumulation and waits for the engine's segment output, with a watchdog, before admitting the next ROI. It sits between the HEG-side input FIFOs and the LSF engine and exposes status counters for the control/spy interface.

## Interface
- ROI_W, HEG2SFSLC_LEN: ROI word width.
- HIT_W, HEG2SFHIT_LEN: hit word width.
- TIMEOUT_CYCLES, 1024: cycles allowed in WAIT_DONE before abort.
- CNT_W, 16: width of the status counters.

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- resetbar  in  1  asynchronous, active-low reset.
- roi_data  in  ROI_W  head of ROI FIFO (first-word-fall-through, valid while !roi_empty).
- roi_empty  in  1  ROI FIFO empty.
- roi_re  out  1  ROI pop.
- hit_data  in  HIT_W  head of hit FIFO (FWFT).
- hit_last  in  1  marks hit_data as the final hit of the current event; valid while !hit_empty.
- hit_empty  in  1  hit FIFO empty.
- hit_re  out  1  hit pop.
- histogram_accumulation_count  in  10  max hits per event; 0 = unlimited.
- freeze  in  1  when 1, no new ROI is admitted.
- eng_roi  out  ROI_W  registered ROI to engine.
- eng_roi_vld  out  1  1-cycle strobe.
- eng_hit  out  HIT_W  registered hit to engine.
- eng_hit_vld  out  1  hit strobe.
- eng_eof  out  1  1-cycle end-of-accumulation strobe.
- eng_done  in  1  engine segment-output valid.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; cleared only by reset.
- events_done  out  CNT_W  events completed with eng_done; wraps.
- dropped_hits  out  CNT_W  hits discarded in DRAIN; saturates at all-ones.

## Operation
The state machine has five states: IDLE, HITS, DRAIN, FLUSH and WAIT_DONE.

- **IDLE**
  - roi_re = !roi_empty && !freeze, combinational.
  - On a pop: eng_roi <= roi_data, eng_roi_vld <= 1 on the next edge, hit_cnt <= 0, go to HITS.
- **HITS**
  - hit_re = !hit_empty, combinational, so 1 hit/cycle max.
  - On each pop: eng_hit <= hit_data, eng_hit_vld <= 1, hit_cnt++.
  - If the popped hit has hit_last=1, go to FLUSH. This takes priority over the limit.
  - Else, if limit != 0 and hit_cnt+1 == limit, go to DRAIN.
  - hit_empty stalls the state with no timeout.
- **DRAIN**
  - hit_re = !hit_empty. No eng_hit_vld.
  - dropped_hits++ per pop, saturating.
  - A popped hit with hit_last=1 goes to FLUSH.
- **FLUSH**
  - eng_eof <= 1 for one cycle.
  - wd_cnt <= 0, go to WAIT_DONE.
- **WAIT_DONE**
  - eng_done=1: events_done++, go to IDLE.
  - wd_cnt == TIMEOUT_CYCLES-1 with no eng_done: timeout_err <= 1, go to IDLE, events_done unchanged.
  - If eng_done coincides with the final watchdog cycle, done wins.
- **General rules**
  - eng_done outside WAIT_DONE is ignored.
  - histogram_accumulation_count is sampled on every HITS pop, not latched.
  - freeze affects only IDLE; an event in progress always completes.
  - hit_cnt is 10 bits. With limit 0 it wraps silently.

## Timing
- **Reset**
  - Asserting resetbar (low) immediately forces state IDLE.
  - All outputs go to 0 (eng_roi, eng_hit, strobes, counters, timeout_err).
  - Mid-event reset abandons the event; FIFO contents are untouched.
- **Latencies**
  - roi_re is combinational in IDLE; eng_roi_vld follows 1 cycle after the roi_re cycle.
  - Hit pop cycle N gives eng_hit_vld at N+1.
  - A last pop at cycle N gives eng_eof at N+2: FLUSH occupies N+1, and the strobe registers at the N+2 edge.
- **Event rate**
  - Minimum event length: 1 (IDLE) + H (hits) + 1 (FLUSH) + 1 or more (WAIT_DONE) cycles.
  - The next roi_re can occur no earlier than the cycle after eng_done.
- **Output rules**
  - roi_re and hit_re are never asserted in the same cycle.
  - Neither is asserted while its FIFO reports empty.

## Test plan
- **Single event:** ROI A, 3 hits with the 3rd last, limit 10, eng_done 5 cycles after eng_eof.
  - eng_roi_vld once with A.
  - eng_hit_vld on 3 consecutive cycles.
  - eng_eof 2 cycles after the last pop.
  - events_done=1, busy low after done.
- **Limit overflow:** limit 4, 7 hits with the 7th last.
  - Exactly 4 eng_hit_vld.
  - dropped_hits=3.
  - eng_eof after the 7th pop.
- **Watchdog:** TIMEOUT_CYCLES=16, eng_done never asserted.
  - timeout_err=1 exactly 16 cycles after entering WAIT_DONE.
  - State returns to IDLE; events_done=0.
  - The next ROI is processed normally.
- **Freeze and hit stall:** freeze=1 with 2 ROIs queued, then release; insert hit_empty gaps mid-event.
  - No roi_re while frozen.
  - Events are processed in order.
  - hit_re is never asserted while hit_empty=1.
- **Reset mid-event and boundaries:**
  - resetbar low in HITS: all outputs 0 immediately, then a clean restart.
  - limit=1 with the first hit last: FLUSH, not DRAIN.
  - eng_done on the final watchdog cycle: counted, no timeout_err.

Source files
------------

// File: rtl/lsf_event_sequencer.sv
// Admits one ROI at a time and streams its MDT hits into the Legendre segment finder.
// Hits beyond the accumulation limit are discarded, and a watchdog guards the engine's done strobe.
module lsf_event_sequencer #(
    parameter int unsigned ROI_W          = 32,
    parameter int unsigned HIT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clock,
    input  logic             resetbar,
    input  logic [ROI_W-1:0] roi_data,
    input  logic             roi_empty,
    output logic             roi_re,
    input  logic [HIT_W-1:0] hit_data,
    input  logic             hit_last,
    input  logic             hit_empty,
    output logic             hit_re,
    input  logic [9:0]       histogram_accumulation_count,
    input  logic             freeze,
    output logic [ROI_W-1:0] eng_roi,
    output logic             eng_roi_vld,
    output logic [HIT_W-1:0] eng_hit,
    output logic             eng_hit_vld,
    output logic             eng_eof,
    input  logic             eng_done,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] events_done,
    output logic [CNT_W-1:0] dropped_hits
);

    localparam int unsigned LIM_W = 10;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HITS,
        DRAIN,
        FLUSH,
        WAIT_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [LIM_W-1:0]   hit_cnt, hit_cnt_nxt, hit_cnt_inc;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_nxt;
    logic [ROI_W-1:0]   eng_roi_nxt;
    logic [HIT_W-1:0]   eng_hit_nxt;
    logic               eng_roi_vld_nxt;
    logic               eng_hit_vld_nxt;
    logic               eng_eof_nxt;
    logic               busy_nxt;
    logic               timeout_err_nxt;
    logic [CNT_W-1:0]   events_done_nxt;
    logic [CNT_W-1:0]   dropped_hits_nxt;

    assign hit_cnt_inc = hit_cnt + LIM_W'(1);

    // State and all registered outputs.
    always_ff @(posedge clock or negedge resetbar) begin
        if (!resetbar) begin
            state        <= IDLE;
            hit_cnt      <= '0;
            wd_cnt       <= '0;
            eng_roi      <= '0;
            eng_roi_vld  <= 1'b0;
            eng_hit      <= '0;
            eng_hit_vld  <= 1'b0;
            eng_eof      <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            events_done  <= '0;
            dropped_hits <= '0;
        end else begin
            state        <= state_nxt;
            hit_cnt      <= hit_cnt_nxt;
            wd_cnt       <= wd_cnt_nxt;
            eng_roi      <= eng_roi_nxt;
            eng_roi_vld  <= eng_roi_vld_nxt;
            eng_hit      <= eng_hit_nxt;
            eng_hit_vld  <= eng_hit_vld_nxt;
            eng_eof      <= eng_eof_nxt;
            busy         <= busy_nxt;
            timeout_err  <= timeout_err_nxt;
            events_done  <= events_done_nxt;
            dropped_hits <= dropped_hits_nxt;
        end
    end

    // Next-state, FIFO pops and next values of the registered outputs.
    always_comb begin
        state_nxt        = state;
        roi_re           = 1'b0;
        hit_re           = 1'b0;
        hit_cnt_nxt      = hit_cnt;
        wd_cnt_nxt       = wd_cnt;
        eng_roi_nxt      = eng_roi;
        eng_roi_vld_nxt  = 1'b0;
        eng_hit_nxt      = eng_hit;
        eng_hit_vld_nxt  = 1'b0;
        eng_eof_nxt      = 1'b0;
        timeout_err_nxt  = timeout_err;
        events_done_nxt  = events_done;
        dropped_hits_nxt = dropped_hits;

        unique case (state)
            IDLE: begin
                // Pops are held off during reset so no FIFO word is lost.
                roi_re = !roi_empty && !freeze && resetbar;
                if (roi_re) begin
                    eng_roi_nxt     = roi_data;
                    eng_roi_vld_nxt = 1'b1;
                    hit_cnt_nxt     = '0;
                    state_nxt       = HITS;
                end
            end
            HITS: begin
                hit_re = !hit_empty && resetbar;
                if (hit_re) begin
                    eng_hit_nxt     = hit_data;
                    eng_hit_vld_nxt = 1'b1;
                    hit_cnt_nxt     = hit_cnt_inc;
                    // The event's last hit wins over reaching the limit on the same pop.
                    if (hit_last) begin
                        state_nxt = FLUSH;
                    end else if ((histogram_accumulation_count != '0) &&
                                 (hit_cnt_inc == histogram_accumulation_count)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                hit_re = !hit_empty && resetbar;
                if (hit_re) begin
                    if (dropped_hits != '1) begin
                        dropped_hits_nxt = dropped_hits + CNT_W'(1);
                    end
                    if (hit_last) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                eng_eof_nxt = 1'b1;
                wd_cnt_nxt  = '0;
                state_nxt   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    events_done_nxt = events_done + CNT_W'(1);
                    state_nxt       = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt + WD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_lsf_event_sequencer.sv
// Directed bench for lsf_event_sequencer: FWFT FIFO models feed the DUT, engine strobes are logged.
module tb_lsf_event_sequencer;

    localparam int unsigned ROI_W = 16;
    localparam int unsigned HIT_W = 16;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic             last;
        logic [HIT_W-1:0] data;
    } hit_word_t;

    logic             clock = 1'b0;
    logic             resetbar = 1'b0;
    logic [ROI_W-1:0] roi_data = '0;
    logic             roi_empty = 1'b1;
    logic             roi_re;
    logic [HIT_W-1:0] hit_data = '0;
    logic             hit_last = 1'b0;
    logic             hit_empty = 1'b1;
    logic             hit_re;
    logic [9:0]       limit = 10'd10;
    logic             freeze = 1'b0;
    logic [ROI_W-1:0] eng_roi;
    logic             eng_roi_vld;
    logic [HIT_W-1:0] eng_hit;
    logic             eng_hit_vld;
    logic             eng_eof;
    logic             eng_done = 1'b0;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] events_done;
    logic [CNT_W-1:0] dropped_hits;

    lsf_event_sequencer #(
        .ROI_W(ROI_W), .HIT_W(HIT_W), .TIMEOUT_CYCLES(16), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .resetbar(resetbar),
        .roi_data(roi_data), .roi_empty(roi_empty), .roi_re(roi_re),
        .hit_data(hit_data), .hit_last(hit_last), .hit_empty(hit_empty), .hit_re(hit_re),
        .histogram_accumulation_count(limit), .freeze(freeze),
        .eng_roi(eng_roi), .eng_roi_vld(eng_roi_vld),
        .eng_hit(eng_hit), .eng_hit_vld(eng_hit_vld), .eng_eof(eng_eof),
        .eng_done(eng_done), .busy(busy), .timeout_err(timeout_err),
        .events_done(events_done), .dropped_hits(dropped_hits)
    );

    always #5 clock = ~clock;

    logic [ROI_W-1:0] roi_q[$];
    hit_word_t        hit_q[$];
    logic [ROI_W-1:0] roi_seen[$];
    logic [HIT_W-1:0] hit_seen[$];
    int               hit_cyc[$];
    int               cyc = 0;
    int               last_pop_cyc = 0;
    int               viol = 0;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO pops and handshake rules, evaluated with the pre-edge values.
    always @(posedge clock) begin
        if (roi_re && hit_re) viol++;
        if (roi_re && (roi_empty || freeze)) viol++;
        if (hit_re && hit_empty) viol++;
        if (roi_re && roi_q.size() > 0) void'(roi_q.pop_front());
        if (hit_re && hit_q.size() > 0) begin
            if (hit_q[0].last) last_pop_cyc = cyc;
            void'(hit_q.pop_front());
        end
        cyc++;
    end

    // Log engine-side strobes, then present the new FIFO heads.
    always @(negedge clock) begin
        if (eng_roi_vld) roi_seen.push_back(eng_roi);
        if (eng_hit_vld) begin
            hit_seen.push_back(eng_hit);
            hit_cyc.push_back(cyc);
        end
        roi_empty = (roi_q.size() == 0);
        roi_data  = roi_empty ? '0 : roi_q[0];
        hit_empty = (hit_q.size() == 0);
        hit_data  = hit_empty ? '0 : hit_q[0].data;
        hit_last  = hit_empty ? 1'b0 : hit_q[0].last;
    end

    task automatic push_hit(input logic [HIT_W-1:0] d, input logic l);
        hit_word_t w;
        w.data = d;
        w.last = l;
        hit_q.push_back(w);
    endtask

    task automatic wait_eof(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (eng_eof) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_eof_seen"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_idle_seen"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        @(negedge clock);
        eng_done = 1'b0;
    endtask

    int eof_at;
    int te_at;
    int base;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_events", 32'(events_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'({eng_roi_vld, eng_hit_vld, eng_eof, timeout_err}), 32'd0);
        resetbar = 1'b1;
        @(negedge clock);

        // Single event: 3 hits, done 5 cycles after eof.
        push_hit(16'h0011, 1'b0);
        push_hit(16'h0012, 1'b0);
        push_hit(16'h0013, 1'b1);
        roi_q.push_back(16'h0A0A);
        wait_eof("single", eof_at);
        check("single_eof_lat", 32'(eof_at - last_pop_cyc), 32'd2);
        repeat (5) @(negedge clock);
        pulse_done();
        wait_idle("single");
        check("single_roi_n", 32'(roi_seen.size()), 32'd1);
        check("single_roi", 32'(roi_seen[0]), 32'h0A0A);
        check("single_hit_n", 32'(hit_seen.size()), 32'd3);
        check("single_hit2", 32'(hit_seen[2]), 32'h0013);
        check("single_hit_consec", 32'(hit_cyc[2] - hit_cyc[0]), 32'd2);
        check("single_events", 32'(events_done), 32'd1);

        // Limit overflow: limit 4, 7 hits.
        limit = 10'd4;
        hit_seen.delete();
        for (int i = 1; i <= 7; i++) push_hit(16'(16'h0020 + i), i == 7);
        roi_q.push_back(16'h0B0B);
        wait_eof("limit", eof_at);
        check("limit_eof_lat", 32'(eof_at - last_pop_cyc), 32'd2);
        pulse_done();
        wait_idle("limit");
        check("limit_hit_n", 32'(hit_seen.size()), 32'd4);
        check("limit_hit3", 32'(hit_seen[3]), 32'h0024);
        check("limit_dropped", 32'(dropped_hits), 32'd3);
        check("limit_events", 32'(events_done), 32'd2);

        // Done on the final watchdog cycle is counted, no timeout.
        limit = 10'd10;
        push_hit(16'h0031, 1'b1);
        roi_q.push_back(16'h0C0C);
        wait_eof("wdlast", eof_at);
        repeat (15) @(negedge clock);
        pulse_done();
        wait_idle("wdlast");
        check("wdlast_events", 32'(events_done), 32'd3);
        check("wdlast_timeout", 32'(timeout_err), 32'd0);

        // Limit 1: first hit last goes to FLUSH; first hit not last drains the rest.
        limit = 10'd1;
        hit_seen.delete();
        push_hit(16'h0041, 1'b1);
        roi_q.push_back(16'h0D0D);
        wait_eof("lim1_last", eof_at);
        check("lim1_last_eof_lat", 32'(eof_at - last_pop_cyc), 32'd2);
        pulse_done();
        wait_idle("lim1_last");
        check("lim1_last_dropped", 32'(dropped_hits), 32'd3);
        push_hit(16'h0042, 1'b0);
        push_hit(16'h0043, 1'b1);
        roi_q.push_back(16'h0D0E);
        wait_eof("lim1_drain", eof_at);
        pulse_done();
        wait_idle("lim1_drain");
        check("lim1_hit_n", 32'(hit_seen.size()), 32'd2);
        check("lim1_hit1", 32'(hit_seen[1]), 32'h0042);
        check("lim1_dropped", 32'(dropped_hits), 32'd4);
        check("lim1_events", 32'(events_done), 32'd5);

        // Freeze with two ROIs queued, then hit FIFO gaps mid-event.
        limit = 10'd0;
        freeze = 1'b1;
        roi_seen.delete();
        hit_seen.delete();
        roi_q.push_back(16'h0D01);
        roi_q.push_back(16'h0D02);
        repeat (10) @(negedge clock);
        check("frz_busy", 32'(busy), 32'd0);
        check("frz_roi_n", 32'(roi_seen.size()), 32'd0);
        freeze = 1'b0;
        repeat (4) @(negedge clock);
        push_hit(16'h0051, 1'b0);
        repeat (3) @(negedge clock);
        push_hit(16'h0052, 1'b1);
        wait_eof("frz_ev1", eof_at);
        pulse_done();
        repeat (4) @(negedge clock);
        push_hit(16'h0053, 1'b1);
        wait_eof("frz_ev2", eof_at);
        pulse_done();
        wait_idle("frz");
        check("frz_roi_n2", 32'(roi_seen.size()), 32'd2);
        check("frz_roi0", 32'(roi_seen[0]), 32'h0D01);
        check("frz_roi1", 32'(roi_seen[1]), 32'h0D02);
        check("frz_hit_n", 32'(hit_seen.size()), 32'd3);
        check("frz_hit2", 32'(hit_seen[2]), 32'h0053);
        check("frz_events", 32'(events_done), 32'd7);

        // Watchdog: no done, timeout_err 16 cycles after entering WAIT_DONE.
        roi_seen.delete();
        push_hit(16'h0061, 1'b1);
        roi_q.push_back(16'h0E0E);
        wait_eof("wd", eof_at);
        te_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (timeout_err) begin
                te_at = cyc;
                break;
            end
            @(negedge clock);
        end
        check("wd_delay", 32'(te_at - eof_at), 32'd16);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_events", 32'(events_done), 32'd7);
        push_hit(16'h0062, 1'b1);
        roi_q.push_back(16'h0E0F);
        wait_eof("wd_next", eof_at);
        pulse_done();
        wait_idle("wd_next");
        check("wd_next_roi", 32'(roi_seen[roi_seen.size() - 1]), 32'h0E0F);
        check("wd_next_events", 32'(events_done), 32'd8);
        check("wd_sticky", 32'(timeout_err), 32'd1);

        // Reset in HITS, then a clean restart.
        base = hit_seen.size();
        push_hit(16'h0071, 1'b0);
        push_hit(16'h0072, 1'b0);
        roi_q.push_back(16'h0F01);
        for (int i = 0; i < 50 && hit_seen.size() < base + 2; i++) @(negedge clock);
        check("rstm_hits_before", 32'(hit_seen.size() - base), 32'd2);
        @(posedge clock);
        #1 resetbar = 1'b0;
        #1;
        check("rstm_regs", 32'({eng_roi_vld, eng_hit_vld, eng_eof, busy, timeout_err}), 32'd0);
        check("rstm_data", 32'({eng_roi, eng_hit}), 32'd0);
        check("rstm_cnts", 32'({events_done, dropped_hits}), 32'd0);
        check("rstm_re", 32'({roi_re, hit_re}), 32'd0);
        hit_q.delete();
        repeat (2) @(negedge clock);
        resetbar = 1'b1;
        push_hit(16'h0073, 1'b1);
        roi_q.push_back(16'h0F02);
        wait_eof("rstm_restart", eof_at);
        pulse_done();
        wait_idle("rstm_restart");
        check("rstm_restart_roi", 32'(eng_roi), 32'h0F02);
        check("rstm_restart_hit", 32'(eng_hit), 32'h0073);
        check("rstm_restart_events", 32'(events_done), 32'd1);

        check("re_rules", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
